// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read,
// live fill count, synchronous flush and sticky overflow/underflow flags.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH             = 16,
    parameter int unsigned DEPTH                  = 1024,
    parameter bit          FWFT                   = 1'b0,
    parameter int unsigned ALMOST_FULL_THRESHOLD  = 16,
    parameter int unsigned ALMOST_EMPTY_THRESHOLD = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    clr_err_i,
    input  logic                    wr_en_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    output logic                    full_o,
    output logic                    almost_full_o,
    output logic                    overflow_o,
    input  logic                    rd_en_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_valid_o,
    output logic                    empty_o,
    output logic                    almost_empty_o,
    output logic                    underflow_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - ALMOST_FULL_THRESHOLD);
    localparam logic [CW-1:0] AE_LVL   = CW'(ALMOST_EMPTY_THRESHOLD);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [CW-1:0]         mem_cnt;
    logic                  full;
    logic                  empty;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  mem_we;
    logic                  mem_re;

    // Status is decoded only from registered state, never from requests.
    assign full    = (count_q == FULL_LVL);
    assign empty   = FWFT ? !rd_valid_q : (count_q == '0);
    assign mem_cnt = wr_ptr_q - rd_ptr_q;

    always_comb begin
        wr_ok      = wr_en_i && !full;
        rd_ok      = rd_en_i && !empty;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_valid_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;

        ovf_d = clr_err_i ? 1'b0 : ovf_q;
        udf_d = clr_err_i ? 1'b0 : udf_q;
        if (wr_en_i && full) ovf_d = 1'b1;
        if (rd_en_i && empty) udf_d = 1'b1;

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            rd_valid_d = 1'b0;
        end else begin
            if (wr_ok) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + ONE;
            end

            if (wr_ok && !rd_ok) count_d = count_q + ONE;
            if (rd_ok && !wr_ok) count_d = count_q - ONE;

            if (!FWFT) begin
                rd_valid_d = rd_ok;
                if (rd_ok) begin
                    mem_re   = 1'b1;
                    rd_ptr_d = rd_ptr_q + ONE;
                end
            end else begin
                // Refill the output register whenever it is free or being consumed.
                if ((mem_cnt != '0) && (!rd_valid_q || rd_ok)) begin
                    mem_re     = 1'b1;
                    rd_ptr_d   = rd_ptr_q + ONE;
                    rd_valid_d = 1'b1;
                end else if (rd_ok) begin
                    rd_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (mem_re) begin
            rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    assign full_o         = full;
    assign almost_full_o  = (count_q >= AF_LVL);
    assign overflow_o     = ovf_q;
    assign rd_data_o      = rd_data_q;
    assign rd_valid_o     = rd_valid_q;
    assign empty_o        = empty;
    assign almost_empty_o = (count_q <= AE_LVL);
    assign underflow_o    = udf_q;
    assign count_o        = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a standard-read and an FWFT instance
// share stimulus; each section checks the instance it targets.
module tb_sync_fifo;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        clr_err;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;

    logic        s_full, s_af, s_ovf, s_rdv, s_empty, s_ae, s_udf;
    logic [15:0] s_rdata;
    logic [4:0]  s_count;

    logic        f_full, f_af, f_ovf, f_rdv, f_empty, f_ae, f_udf;
    logic [15:0] f_rdata;
    logic [4:0]  f_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb[$];
    logic [15:0] exp_w;
    logic [15:0] fw_vals [3];

    sync_fifo #(
        .DATA_WIDTH(16), .DEPTH(16), .FWFT(1'b0),
        .ALMOST_FULL_THRESHOLD(4), .ALMOST_EMPTY_THRESHOLD(4)
    ) u_std (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clr_err_i(clr_err),
        .wr_en_i(wr_en), .wr_data_i(wr_data),
        .full_o(s_full), .almost_full_o(s_af), .overflow_o(s_ovf),
        .rd_en_i(rd_en), .rd_data_o(s_rdata), .rd_valid_o(s_rdv),
        .empty_o(s_empty), .almost_empty_o(s_ae), .underflow_o(s_udf),
        .count_o(s_count)
    );

    sync_fifo #(
        .DATA_WIDTH(16), .DEPTH(16), .FWFT(1'b1),
        .ALMOST_FULL_THRESHOLD(4), .ALMOST_EMPTY_THRESHOLD(4)
    ) u_fw (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clr_err_i(clr_err),
        .wr_en_i(wr_en), .wr_data_i(wr_data),
        .full_o(f_full), .almost_full_o(f_af), .overflow_o(f_ovf),
        .rd_en_i(rd_en), .rd_data_o(f_rdata), .rd_valid_o(f_rdv),
        .empty_o(f_empty), .almost_empty_o(f_ae), .underflow_o(f_udf),
        .count_o(f_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush   = 1'b0;
        clr_err = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        do_reset();

        chk("rst_empty", s_empty, 1);
        chk("rst_ae", s_ae, 1);
        chk("rst_full", s_full, 0);
        chk("rst_af", s_af, 0);
        chk("rst_ovf", s_ovf, 0);
        chk("rst_udf", s_udf, 0);
        chk("rst_count", s_count, 0);
        chk("rst_rdv", s_rdv, 0);
        chk("rst_rdata", s_rdata, 0);

        // fill with 0..15, thresholds checked at every level
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'(i);
            step();
            chk("fill_count", s_count, i + 1);
            chk("fill_af", s_af, (i + 1 >= 12) ? 1 : 0);
            chk("fill_ae", s_ae, (i + 1 <= 4) ? 1 : 0);
            chk("fill_empty", s_empty, 0);
            chk("fill_full", s_full, (i == 15) ? 1 : 0);
        end
        wr_data = 16'h00AA;
        step();
        chk("ovf_set", s_ovf, 1);
        chk("ovf_count", s_count, 16);
        wr_en = 1'b0;

        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            step();
            chk("drain_valid", s_rdv, 1);
            chk("drain_data", s_rdata, i);
        end
        rd_en = 1'b0;
        step();
        chk("drain_rdv_low", s_rdv, 0);
        chk("drain_hold", s_rdata, 15);
        chk("drain_empty", s_empty, 1);
        chk("drain_count", s_count, 0);

        rd_en = 1'b1;
        step();
        chk("udf_set", s_udf, 1);
        chk("udf_rdv", s_rdv, 0);
        rd_en = 1'b0;

        // steady wr+rd at level 8 across several pointer wraps
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'h0040 + 16'(i);
            sb.push_back(wr_data);
            step();
        end
        for (int c = 0; c < 100; c++) begin
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            wr_data = 16'h0100 + 16'(c);
            sb.push_back(wr_data);
            exp_w = sb.pop_front();
            step();
            chk("ss_data", s_rdata, exp_w);
            chk("ss_count", s_count, 8);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        for (int i = 0; i < 2; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'h0200 + 16'(i);
            step();
        end
        chk("pre_flush", s_count, 10);
        flush   = 1'b1;
        wr_data = 16'h0BAD;
        step();
        chk("fl_count", s_count, 0);
        chk("fl_empty", s_empty, 1);
        chk("fl_rdv", s_rdv, 0);
        chk("fl_ovf", s_ovf, 1);
        flush = 1'b0;
        wr_en = 1'b0;
        step();
        chk("fl_drop", s_count, 0);

        // set condition wins over clear in the same cycle
        rd_en   = 1'b1;
        clr_err = 1'b1;
        step();
        chk("clr_udf_keep", s_udf, 1);
        chk("clr_ovf", s_ovf, 0);
        rd_en = 1'b0;
        step();
        chk("clr_udf", s_udf, 0);
        clr_err = 1'b0;
        rd_en   = 1'b1;
        step();
        chk("udf_again", s_udf, 1);
        rd_en = 1'b0;

        // asynchronous reset in the middle of traffic
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'h0050 + 16'(i);
            step();
        end
        wr_en = 1'b0;
        chk("mid_count", s_count, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count", s_count, 0);
        chk("ar_empty", s_empty, 1);
        chk("ar_ae", s_ae, 1);
        chk("ar_udf", s_udf, 0);
        chk("ar_rdata", s_rdata, 0);
        chk("ar_rdv", s_rdv, 0);
        step();
        rst_n = 1'b1;
        rd_en = 1'b1;
        step();
        chk("post_rst_udf", s_udf, 1);
        rd_en = 1'b0;

        // first-word-fall-through instance
        do_reset();
        chk("fw_rst_empty", f_empty, 1);
        wr_en   = 1'b1;
        wr_data = 16'h1234;
        step();
        wr_en = 1'b0;
        chk("fw_n_rdv", f_rdv, 0);
        chk("fw_n_count", f_count, 1);
        step();
        chk("fw_n1_rdv", f_rdv, 1);
        chk("fw_n1_data", f_rdata, 16'h1234);
        chk("fw_n1_empty", f_empty, 0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("fw_rd_empty", f_empty, 1);
        chk("fw_rd_count", f_count, 0);

        fw_vals[0] = 16'hA001;
        fw_vals[1] = 16'hB002;
        fw_vals[2] = 16'hC003;
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = fw_vals[i];
            step();
        end
        wr_en = 1'b0;
        step();
        chk("fw_b2b_count", f_count, 3);
        for (int i = 0; i < 3; i++) begin
            chk("fw_b2b_rdv", f_rdv, 1);
            chk("fw_b2b_data", f_rdata, fw_vals[i]);
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        chk("fw_b2b_empty", f_empty, 1);
        chk("fw_b2b_cnt0", f_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
